// File: rtl/clint_pkg.sv
// Shared constants, address-map selector type and address decoder for the
// core-local interruptor (clint_mh).
package clint_pkg;

  localparam int XLEN = 32;

  localparam logic [31:0] CLINT_MSIP_OFS     = 32'h0000_0000;
  localparam logic [31:0] CLINT_MTIMECMP_OFS = 32'h0000_4000;
  localparam logic [31:0] CLINT_MTIME_OFS    = 32'h0000_BFF8;

  localparam logic [31:0] CLINT_MSIP_STRIDE  = 32'd4;
  localparam logic [31:0] CLINT_CMP_STRIDE   = 32'd8;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_MSIP,
    SEL_CMP_LO,
    SEL_CMP_HI,
    SEL_MTIME_LO,
    SEL_MTIME_HI
  } clint_sel_t;

  typedef struct packed {
    clint_sel_t  sel;
    logic [3:0]  hart;
  } clint_dec_t;

  // Offsets past the mtime words (including everything beyond the window) decode to SEL_NONE.
  function automatic clint_dec_t clint_decode(input logic [31:0] ofs, input logic [31:0] n_harts);
    clint_dec_t  d;
    logic [31:0] idx;
    d.sel  = SEL_NONE;
    d.hart = 4'd0;
    idx    = 32'd0;
    if (ofs[1:0] != 2'b00) begin
      d.sel = SEL_NONE;
    end else if (ofs < CLINT_MTIMECMP_OFS) begin
      idx = (ofs - CLINT_MSIP_OFS) >> 2;
      if (idx < n_harts) begin
        d.sel  = SEL_MSIP;
        d.hart = idx[3:0];
      end else begin
        d.sel = SEL_NONE;
      end
    end else if (ofs < CLINT_MTIME_OFS) begin
      idx = (ofs - CLINT_MTIMECMP_OFS) >> 3;
      if (idx < n_harts) begin
        d.sel  = ofs[2] ? SEL_CMP_HI : SEL_CMP_LO;
        d.hart = idx[3:0];
      end else begin
        d.sel = SEL_NONE;
      end
    end else if (ofs == CLINT_MTIME_OFS) begin
      d.sel = SEL_MTIME_LO;
    end else if (ofs == CLINT_MTIME_OFS + 32'd4) begin
      d.sel = SEL_MTIME_HI;
    end else begin
      d.sel = SEL_NONE;
    end
    return d;
  endfunction

endpackage

// File: rtl/clint_tick_gen.sv
// mtime prescaler: asserts o_tick once every TICK_DIV cycles; i_clr restarts the count.
module clint_tick_gen #(
  parameter int TICK_DIV = 1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  output logic o_tick
);

  localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_r;

  // Count 0..TICK_DIV-1 and wrap
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      cnt_r <= '0;
    end else if (i_clr || (cnt_r == LAST)) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

  assign o_tick = (cnt_r == LAST);

endmodule

// File: rtl/clint_mh.sv
// Multi-hart CLINT: shared 64-bit mtime, per-hart mtimecmp and msip, registered bus reads.
// Optional macro CLINT_MTIME_LATCH_EN: reading mtime lo latches mtime hi for the next hi read.
module clint_mh
  import clint_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
  parameter int          N_HARTS   = 1,
  parameter int          TICK_DIV  = 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_wen,
  input  logic               i_ren,
  input  logic [XLEN-1:0]    i_addr,
  input  logic [XLEN-1:0]    i_wrdata,
  output logic [XLEN-1:0]    o_rddata,
  output logic               o_rvalid,
  output logic [N_HARTS-1:0] o_msip,
  output logic [N_HARTS-1:0] o_mtip
);

  logic [31:0] ofs_s;
  clint_dec_t  dec_s;
  logic        mtime_wr_s;
  logic        tick_s;
  logic [63:0] mtime_r;
  logic [31:0] rd_hart_s [N_HARTS];
  logic [31:0] hart_rd_s;
  logic [31:0] hi_rd_s;
  logic [31:0] rd_s;

  assign ofs_s      = i_addr - BASE_ADDR;
  assign dec_s      = clint_decode(ofs_s, 32'(N_HARTS));
  assign mtime_wr_s = i_wen && ((dec_s.sel == SEL_MTIME_LO) || (dec_s.sel == SEL_MTIME_HI));

  clint_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clr  (mtime_wr_s),
    .o_tick (tick_s)
  );

  // mtime: a write replaces one half and swallows any coincident tick
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      mtime_r <= 64'd0;
    end else if (i_wen && (dec_s.sel == SEL_MTIME_LO)) begin
      mtime_r[31:0] <= i_wrdata;
    end else if (i_wen && (dec_s.sel == SEL_MTIME_HI)) begin
      mtime_r[63:32] <= i_wrdata;
    end else if (tick_s) begin
      mtime_r <= mtime_r + 64'd1;
    end
  end

  for (genvar h = 0; h < N_HARTS; h++) begin : g_hart
    logic [63:0] cmp_r;
    logic        msip_r;
    logic        mtip_r;
    logic        sel_s;

    assign sel_s = (dec_s.hart == 4'(h));

    // Per-hart mtimecmp/msip storage and timer compare
    always_ff @(posedge i_clk) begin
      if (!i_rst) begin
        cmp_r  <= 64'hFFFF_FFFF_FFFF_FFFF;
        msip_r <= 1'b0;
        mtip_r <= 1'b0;
      end else begin
        mtip_r <= (mtime_r >= cmp_r);
        if (i_wen && sel_s) begin
          case (dec_s.sel)
            SEL_MSIP:   msip_r        <= i_wrdata[0];
            SEL_CMP_LO: cmp_r[31:0]   <= i_wrdata;
            SEL_CMP_HI: cmp_r[63:32]  <= i_wrdata;
            default:    msip_r        <= msip_r;
          endcase
        end
      end
    end

    assign rd_hart_s[h] = !sel_s                     ? 32'd0 :
                          (dec_s.sel == SEL_MSIP)    ? {31'd0, msip_r} :
                          (dec_s.sel == SEL_CMP_LO)  ? cmp_r[31:0] :
                          (dec_s.sel == SEL_CMP_HI)  ? cmp_r[63:32] : 32'd0;
    assign o_msip[h] = msip_r;
    assign o_mtip[h] = mtip_r;
  end

`ifdef CLINT_MTIME_LATCH_EN
  logic [31:0] shadow_r;
  logic        shadow_vld_r;

  // Snapshot of mtime hi taken on a lo read; any mtime write makes it stale
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      shadow_r     <= 32'd0;
      shadow_vld_r <= 1'b0;
    end else if (mtime_wr_s) begin
      shadow_vld_r <= 1'b0;
    end else if (i_ren && (dec_s.sel == SEL_MTIME_LO)) begin
      shadow_r     <= mtime_r[63:32];
      shadow_vld_r <= 1'b1;
    end else if (i_ren && (dec_s.sel == SEL_MTIME_HI)) begin
      shadow_vld_r <= 1'b0;
    end
  end

  assign hi_rd_s = shadow_vld_r ? shadow_r : mtime_r[63:32];
`else
  assign hi_rd_s = mtime_r[63:32];
`endif

  // Read-data mux over pre-write register values
  always_comb begin
    hart_rd_s = 32'd0;
    for (int h = 0; h < N_HARTS; h++) begin
      hart_rd_s = hart_rd_s | rd_hart_s[h];
    end
    case (dec_s.sel)
      SEL_MTIME_LO: rd_s = mtime_r[31:0];
      SEL_MTIME_HI: rd_s = hi_rd_s;
      default:      rd_s = hart_rd_s;
    endcase
  end

  // Registered read response; data holds between reads
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      o_rddata <= 32'd0;
      o_rvalid <= 1'b0;
    end else begin
      o_rvalid <= i_ren;
      if (i_ren) begin
        o_rddata <= rd_s;
      end
    end
  end

endmodule
